// File: rtl/wb_stage_if.sv
// MEM->WB bundle: latched memory-stage fields plus writeback, forwarding and status outputs.
interface wb_stage_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned RADDR = 5
);
   logic             mem_valid;
   logic             mem_wen;
   logic [RADDR-1:0] mem_ws;
   logic [1:0]       mem_sel;
   logic [2:0]       mem_ld_type;
   logic [XLEN-1:0]  mem_alu_res;
   logic [XLEN-1:0]  mem_load_data;
   logic [XLEN-1:0]  mem_pc4;
   logic [XLEN-1:0]  mem_imm;
   logic             stall;
   logic             flush;

   logic [RADDR-1:0] ws;
   logic [XLEN-1:0]  wd;
   logic             wf;
   logic             fwd_valid;
   logic [RADDR-1:0] fwd_ws;
   logic [XLEN-1:0]  fwd_data;
   logic             misalign_err;
   logic [31:0]      retired;

   modport master (
      output mem_valid, mem_wen, mem_ws, mem_sel, mem_ld_type, mem_alu_res,
             mem_load_data, mem_pc4, mem_imm, stall, flush,
      input  ws, wd, wf, fwd_valid, fwd_ws, fwd_data, misalign_err, retired
   );

   modport slave (
      input  mem_valid, mem_wen, mem_ws, mem_sel, mem_ld_type, mem_alu_res,
             mem_load_data, mem_pc4, mem_imm, stall, flush,
      output ws, wd, wf, fwd_valid, fwd_ws, fwd_data, misalign_err, retired
   );
endinterface

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback: result mux, load extension, single-pulse
// register-file write, forwarding tap and retired-instruction counter.
module wb_stage #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned RADDR = 5
) (
   input  logic      clk,
   input  logic      rst_n,
   wb_stage_if.slave wb
);

   logic             valid_q;
   logic             wen_q;
   logic [RADDR-1:0] ws_q;
   logic [1:0]       sel_q;
   logic [2:0]       ld_q;
   logic [XLEN-1:0]  alu_q;
   logic [XLEN-1:0]  load_q;
   logic [XLEN-1:0]  pc4_q;
   logic [XLEN-1:0]  imm_q;
   logic             written_q;
   logic [31:0]      retired_q;
   logic [31:0]      retired_d;

   logic [15:0]      half;
   logic [7:0]       byt;
   logic [XLEN-1:0]  ld_ext;
   logic [XLEN-1:0]  result;
   logic             misaligned;
   logic             wr_ok;

   // Entry capture: flush beats stall; a stalled entry is marked written after its first cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q   <= 1'b0;
         wen_q     <= 1'b0;
         ws_q      <= '0;
         sel_q     <= '0;
         ld_q      <= '0;
         alu_q     <= '0;
         load_q    <= '0;
         pc4_q     <= '0;
         imm_q     <= '0;
         written_q <= 1'b0;
         retired_q <= '0;
      end else begin
         retired_q <= retired_d;
         if (wb.flush) begin
            valid_q   <= 1'b0;
            written_q <= 1'b0;
         end else if (wb.stall) begin
            written_q <= written_q | valid_q;
         end else begin
            valid_q   <= wb.mem_valid;
            wen_q     <= wb.mem_wen;
            ws_q      <= wb.mem_ws;
            sel_q     <= wb.mem_sel;
            ld_q      <= wb.mem_ld_type;
            alu_q     <= wb.mem_alu_res;
            load_q    <= wb.mem_load_data;
            pc4_q     <= wb.mem_pc4;
            imm_q     <= wb.mem_imm;
            written_q <= 1'b0;
         end
      end
   end

   // Count each valid entry once, at the end of its first resident cycle.
   always_comb begin
      retired_d = retired_q;
      if (valid_q && !written_q) begin
         retired_d = retired_q + 32'd1;
      end
   end

   // Little-endian sub-word select and extension, then writeback result mux.
   always_comb begin
      half = alu_q[1] ? load_q[31:16] : load_q[15:0];
      byt  = load_q[7:0];
      case (alu_q[1:0])
         2'b01:   byt = load_q[15:8];
         2'b10:   byt = load_q[23:16];
         2'b11:   byt = load_q[31:24];
         default: byt = load_q[7:0];
      endcase
      case (ld_q)
         3'b001:  ld_ext = {{(XLEN-16){half[15]}}, half};
         3'b010:  ld_ext = {{(XLEN-16){1'b0}}, half};
         3'b011:  ld_ext = {{(XLEN-8){byt[7]}}, byt};
         3'b100:  ld_ext = {{(XLEN-8){1'b0}}, byt};
         default: ld_ext = load_q;
      endcase
      case (sel_q)
         2'b01:   result = ld_ext;
         2'b10:   result = pc4_q;
         2'b11:   result = imm_q;
         default: result = alu_q;
      endcase
   end

   // Outputs: zero while invalid; wf pulses once per entry, forwarding holds for the residency.
   always_comb begin
      misaligned      = (sel_q == 2'b01) && ((ld_q == 3'b001) || (ld_q == 3'b010)) && alu_q[0];
      wr_ok           = valid_q && wen_q && (ws_q != '0) && !misaligned;
      wb.ws           = valid_q ? ws_q : '0;
      wb.wd           = valid_q ? result : '0;
      wb.wf           = wr_ok && !written_q;
      wb.fwd_valid    = wr_ok;
      wb.fwd_ws       = valid_q ? ws_q : '0;
      wb.fwd_data     = valid_q ? result : '0;
      wb.misalign_err = valid_q && misaligned && !written_q;
      wb.retired      = retired_q;
   end

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: stimulus pushes expected writes, a monitor pops on wf.
module tb_wb_stage;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;
   int   exp_ret;
   logic [36:0] exp_q[$];

   wb_stage_if bus ();

   wb_stage dut (
      .clk   (clk),
      .rst_n (rst_n),
      .wb    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic put(input logic v, input logic w, input logic [4:0] s, input logic [1:0] sl,
                      input logic [2:0] lt, input logic [31:0] a, input logic [31:0] ld,
                      input logic [31:0] p, input logic [31:0] im);
      bus.mem_valid     = v;
      bus.mem_wen       = w;
      bus.mem_ws        = s;
      bus.mem_sel       = sl;
      bus.mem_ld_type   = lt;
      bus.mem_alu_res   = a;
      bus.mem_load_data = ld;
      bus.mem_pc4       = p;
      bus.mem_imm       = im;
   endtask

   task automatic idle;
      put(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0);
   endtask

   // Issue a valid entry and record the write it must produce (if any).
   task automatic issue(input logic [4:0] s, input logic [1:0] sl, input logic [2:0] lt,
                        input logic [31:0] a, input logic [31:0] ld, input logic [31:0] p,
                        input logic [31:0] im, input logic exp_wf, input logic [31:0] exp_wd);
      put(1'b1, 1'b1, s, sl, lt, a, ld, p, im);
      if (exp_wf) exp_q.push_back({s, exp_wd});
      exp_ret++;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ws"}, 32'(bus.ws), 32'h0);
      chk({tag, "_wd"}, bus.wd, 32'h0);
      chk({tag, "_wf"}, 32'(bus.wf), 32'h0);
      chk({tag, "_fwd_valid"}, 32'(bus.fwd_valid), 32'h0);
      chk({tag, "_fwd_ws"}, 32'(bus.fwd_ws), 32'h0);
      chk({tag, "_fwd_data"}, bus.fwd_data, 32'h0);
      chk({tag, "_misalign"}, 32'(bus.misalign_err), 32'h0);
   endtask

   // Monitor: every wf pulse must match the oldest expected write.
   initial begin
      logic [36:0] e;
      forever begin
         @(negedge clk);
         if (bus.wf === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL wf_unexpected actual ws=%0d wd=0x%08h required no write",
                        bus.ws, bus.wd);
            end else begin
               e = exp_q.pop_front();
               chk("wf_ws", 32'(bus.ws), 32'(e[36:32]));
               chk("wf_wd", bus.wd, e[31:0]);
               chk("fwd_data_eq_wd", bus.fwd_data, e[31:0]);
            end
         end
      end
   end

   initial begin
      checks   = 0;
      failures = 0;
      exp_ret  = 0;
      rst_n    = 1'b0;
      bus.stall = 1'b0;
      bus.flush = 1'b0;
      idle();
      tick();
      tick();
      chk_zero("reset");
      chk("reset_retired", bus.retired, 32'h0);
      rst_n = 1'b1;

      // ALU writeback
      issue(5'd5, 2'b00, 3'b000, 32'h0000_1234, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0000_1234);
      tick();
      chk("alu_fwd_valid", 32'(bus.fwd_valid), 32'h1);
      chk("alu_retired_pre", bus.retired, 32'h0);
      idle();
      tick();
      chk("alu_retired", bus.retired, 32'h1);
      chk("alu_wf_off", 32'(bus.wf), 32'h0);

      // Back-to-back loads and selects
      issue(5'd3, 2'b01, 3'b011, 32'h0000_0102, 32'h0080_0000, 32'h0, 32'h0, 1'b1, 32'hFFFF_FF80);
      tick();
      issue(5'd4, 2'b01, 3'b100, 32'h0000_0102, 32'h0080_0000, 32'h0, 32'h0, 1'b1, 32'h0000_0080);
      tick();
      issue(5'd16, 2'b01, 3'b011, 32'h0000_0003, 32'h7F00_0000, 32'h0, 32'h0, 1'b1, 32'h0000_007F);
      tick();
      issue(5'd6, 2'b01, 3'b001, 32'h0000_0010, 32'h1234_8001, 32'h0, 32'h0, 1'b1, 32'hFFFF_8001);
      tick();
      issue(5'd8, 2'b01, 3'b010, 32'h0000_0012, 32'hABCD_0000, 32'h0, 32'h0, 1'b1, 32'h0000_ABCD);
      tick();
      issue(5'd9, 2'b01, 3'b000, 32'h0000_0013, 32'hDEAD_BEEF, 32'h0, 32'h0, 1'b1, 32'hDEAD_BEEF);
      tick();
      issue(5'd2, 2'b01, 3'b111, 32'h0000_0020, 32'h0BAD_F00D, 32'h0, 32'h0, 1'b1, 32'h0BAD_F00D);
      tick();
      issue(5'd10, 2'b11, 3'b000, 32'h0000_0001, 32'h0, 32'h0, 32'h0000_55AA, 1'b1, 32'h0000_55AA);
      tick();
      idle();
      tick();
      chk("burst_retired", bus.retired, 32'(exp_ret));

      // Misaligned halfword: no write, one-cycle error, still retires
      issue(5'd11, 2'b01, 3'b001, 32'h0000_0001, 32'h1111_2222, 32'h0, 32'h0, 1'b0, 32'h0);
      tick();
      chk("mis_err", 32'(bus.misalign_err), 32'h1);
      chk("mis_fwd_valid", 32'(bus.fwd_valid), 32'h0);
      chk("mis_wf", 32'(bus.wf), 32'h0);
      idle();
      tick();
      chk("mis_err_off", 32'(bus.misalign_err), 32'h0);
      chk("mis_retired", bus.retired, 32'(exp_ret));

      // Stall for three resident cycles
      issue(5'd7, 2'b00, 3'b000, 32'h0000_0077, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0000_0077);
      tick();
      bus.stall = 1'b1;
      put(1'b1, 1'b1, 5'd12, 2'b00, 3'b000, 32'h0000_0C0C, 32'h0, 32'h0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         chk("stall_fwd_valid", 32'(bus.fwd_valid), 32'h1);
         chk("stall_fwd_ws", 32'(bus.fwd_ws), 32'h7);
         chk("stall_wd", bus.wd, 32'h0000_0077);
         if (i < 2) tick();
      end
      bus.stall = 1'b0;
      idle();
      tick();
      chk("stall_retired", bus.retired, 32'(exp_ret));

      // Write to r0 suppressed but retired
      issue(5'd0, 2'b10, 3'b000, 32'h0, 32'h0, 32'h0000_0040, 32'h0, 1'b0, 32'h0);
      tick();
      chk("r0_wf", 32'(bus.wf), 32'h0);
      chk("r0_fwd_valid", 32'(bus.fwd_valid), 32'h0);
      chk("r0_wd", bus.wd, 32'h0000_0040);

      // Flush together with stall kills the entry
      issue(5'd13, 2'b00, 3'b000, 32'h0000_1313, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0000_1313);
      tick();
      chk("r0_retired", bus.retired, 32'(exp_ret - 1));
      bus.flush = 1'b1;
      bus.stall = 1'b1;
      put(1'b1, 1'b1, 5'd20, 2'b00, 3'b000, 32'h0000_2020, 32'h0, 32'h0, 32'h0);
      tick();
      chk_zero("flush");
      chk("flush_retired", bus.retired, 32'(exp_ret));
      bus.flush = 1'b0;
      bus.stall = 1'b0;
      idle();
      tick();

      // Counter wrap
      issue(5'd14, 2'b00, 3'b000, 32'h0000_00AB, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0000_00AB);
      tick();
      force dut.retired_q = 32'hFFFF_FFFF;
      #1;
      release dut.retired_q;
      idle();
      tick();
      chk("wrap_retired", bus.retired, 32'h0);

      // Reset in the middle of a stall
      issue(5'd15, 2'b00, 3'b000, 32'h0000_00F0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0000_00F0);
      tick();
      bus.stall = 1'b1;
      put(1'b1, 1'b1, 5'd21, 2'b00, 3'b000, 32'h0000_2121, 32'h0, 32'h0, 32'h0);
      tick();
      rst_n = 1'b0;
      tick();
      chk_zero("rst_stall");
      chk("rst_stall_retired", bus.retired, 32'h0);
      rst_n = 1'b1;
      tick();
      tick();
      chk("post_rst_wf", 32'(bus.wf), 32'h0);
      chk("post_rst_valid", 32'(bus.fwd_valid), 32'h0);
      bus.stall = 1'b0;
      idle();
      tick();
      tick();

      chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- MEM/WB pipeline register and writeback unit of the 32-bit pipelined processor.
- Latches the memory-stage result, selects and extends the writeback value, and drives the register file write port (ws/wd/wf), one write per retired instruction.
- Also supplies a forwarding tap for the ID/EX operand muxes and a retired-instruction counter.

Parameters:
- XLEN, 32, datapath width.
- RADDR, 5, register address width.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- mem_valid  input  1  MEM stage presents an instruction this cycle.
- mem_wen  input  1  instruction writes a register.
- mem_ws  input  RADDR  destination register.
- mem_sel  input  2  result select: 00 ALU, 01 load, 10 link (PC+4), 11 immediate.
- mem_ld_type  input  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU; others treated as LW.
- mem_alu_res  input  XLEN  ALU result, also the load address.
- mem_load_data  input  XLEN  raw aligned word from data memory.
- mem_pc4  input  XLEN  PC+4.
- mem_imm  input  XLEN  immediate.
- stall  input  1  hold the WB register.
- flush  input  1  kill the WB entry.
- ws  output  RADDR  register file write address.
- wd  output  XLEN  register file write data.
- wf  output  1  register file write enable.
- fwd_valid  output  1  forwarding data is valid.
- fwd_ws  output  RADDR  forwarding destination.
- fwd_data  output  XLEN  forwarding value, identical to wd.
- misalign_err  output  1  one-cycle pulse on a misaligned halfword load.
- retired  output  32  retired-instruction count.

Behaviour:
- Reset (rst_n=0 at posedge): entry valid=0, written flag=0, retired=0. All outputs 0 while the entry is invalid (ws=0, wd=0, wf=0, fwd_*=0, misalign_err=0).
- Capture at each posedge, in priority order:
  - reset;
  - flush: valid<=0;
  - stall: hold all entry state;
  - otherwise: valid<=mem_valid and all mem_* fields are latched, with written<=0.
- Latency: one cycle. A value captured at edge N drives ws/wd at edge N to N+1.
- Result mux, from latched fields:
  - sel 00: alu_res.
  - sel 10: pc4.
  - sel 11: imm.
  - sel 01: extended load.
- Load extension, little-endian, byte offset = alu_res[1:0]:
  - LB/LBU select byte [8*off+7 : 8*off], then sign- or zero-extend.
  - LH/LHU: alu_res[1]=0 selects bits 15:0, alu_res[1]=1 selects bits 31:16, then sign- or zero-extend.
  - LW ignores the offset.
- Misaligned halfword: LH/LHU with alu_res[0]=1 suppresses the write. misalign_err=1 for exactly one cycle, the first cycle the entry is resident; the instruction still counts as retired.
- wf = valid & wen & (ws!=0) & ~written & ~misaligned.
  - written is set at the first posedge the entry is resident, so a stalled entry pulses wf exactly one cycle.
  - The register file writes on level, so a single pulse is mandatory.
- Writes to r0 are suppressed (wf=0); the instruction still retires.
- fwd_valid = valid & wen & (ws!=0) & ~misaligned. It stays high for the whole residency including stall cycles, with fwd_data=wd.
- retired increments by 1 at the posedge ending the first resident cycle of each valid entry. A flushed entry that was already resident for a cycle has already counted. The counter wraps from 0xFFFFFFFF to 0.
- Flush and stall together: flush wins.
- rst_n low mid-stall: the entry is cleared and no pending wf is issued after reset.
- Back-to-back entries with no stall: wf is high on consecutive cycles with a new ws/wd each cycle.

Test Plan:
- Reset then ALU op: mem_valid=1, wen=1, ws=5, sel=00, alu_res=0x0000_1234 -> next cycle ws=5, wd=0x1234, wf=1 for 1 cycle, retired=1.
- LB sign-extend: ld_type=011, alu_res=0x...02, load_data=0x0080_0000 -> wd=0xFFFF_FF80. Same input with LBU -> wd=0x0000_0080.
- LH with alu_res[1:0]=01 -> wf=0, misalign_err pulses 1 cycle, fwd_valid=0, retired increments.
- Stall held 3 cycles on an entry with ws=7 -> wf high only on the first cycle, fwd_valid high all 3 cycles, retired +1 only.
- ws=0 with wen=1, sel=10, pc4=0x40 -> wf=0, fwd_valid=0, retired +1. Flush asserted together with stall on the next entry -> valid=0 and all outputs 0 next cycle.
- Preload retired=0xFFFF_FFFF by forcing, retire one instruction -> retired=0. Assert rst_n=0 during a stall -> outputs 0 next cycle and no wf after release.
